// File: rtl/udp_gen_pkg.sv
// Shared constants, CSR map and FSM state type for the UDP frame generator.
package udp_gen_pkg;

    localparam logic [2:0] CSR_CTRL    = 3'd0;
    localparam logic [2:0] CSR_SRC_IP  = 3'd1;
    localparam logic [2:0] CSR_DST_IP  = 3'd2;
    localparam logic [2:0] CSR_PORTS   = 3'd3;
    localparam logic [2:0] CSR_DMAC_LO = 3'd4;
    localparam logic [2:0] CSR_DMAC_HI = 3'd5;
    localparam logic [2:0] CSR_STATUS  = 3'd6;
    localparam logic [2:0] CSR_COUNT   = 3'd7;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [3:0]  HDR_WORDS      = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_e;

    // Byte-lane merge of a CSR write into the register's current contents.
    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[i*8 +: 8] = be[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        return r;
    endfunction

endpackage

// File: rtl/udp_ip_checksum.sv
// IPv4 header checksum over ten halfwords (checksum field supplied as zero).
module udp_ip_checksum (
    input  logic [15:0] hw0_i,
    input  logic [15:0] hw1_i,
    input  logic [15:0] hw2_i,
    input  logic [15:0] hw3_i,
    input  logic [15:0] hw4_i,
    input  logic [15:0] hw5_i,
    input  logic [15:0] hw6_i,
    input  logic [15:0] hw7_i,
    input  logic [15:0] hw8_i,
    input  logic [15:0] hw9_i,
    output logic [15:0] cksum_o
);

    logic [19:0] sum;
    logic [16:0] fold1;
    logic [15:0] fold2;

    // Ten 16-bit terms fit in 20 bits; two end-around folds always settle.
    assign sum = {4'b0, hw0_i} + {4'b0, hw1_i} + {4'b0, hw2_i} + {4'b0, hw3_i}
               + {4'b0, hw4_i} + {4'b0, hw5_i} + {4'b0, hw6_i} + {4'b0, hw7_i}
               + {4'b0, hw8_i} + {4'b0, hw9_i};
    assign fold1   = {1'b0, sum[15:0]} + {13'b0, sum[19:16]};
    assign fold2   = fold1[15:0] + {15'b0, fold1[16]};
    assign cksum_o = ~fold2;

endmodule

// File: rtl/udp_frame_generator.sv
// Wraps a continuous 32-bit stream into fixed-size Ethernet/IPv4/UDP frames.
// Handshake: a word moves on either port only in a cycle where valid and ready are both high.
module udp_frame_generator
    import udp_gen_pkg::*;
#(
    parameter logic [47:0] SRC_MAC = 48'h0007ED000001,
    parameter logic [7:0]  IP_TTL  = 8'h40
) (
    input  logic        clk_clk,
    input  logic        rst_reset_n,
    input  logic [2:0]  csr_address,
    input  logic        csr_write,
    input  logic [31:0] csr_writedata,
    input  logic [3:0]  csr_byteenable,
    input  logic        csr_read,
    output logic [31:0] csr_readdata,
    input  logic [31:0] data_in_data,
    output logic        data_in_ready,
    input  logic        data_in_valid,
    input  logic [1:0]  data_in_empty,
    input  logic        data_in_endofpacket,
    input  logic        data_in_startofpacket,
    output logic [31:0] data_out_data,
    output logic [1:0]  data_out_empty,
    output logic        data_out_endofpacket,
    output logic        data_out_startofpacket,
    input  logic        data_out_ready,
    output logic        data_out_valid
);

    logic        unused_inputs;
    assign unused_inputs = ^{data_in_empty, data_in_endofpacket, data_in_startofpacket, csr_read};

    // Live configuration
    logic [15:0] size_q;
    logic        enable_q;
    logic [31:0] src_ip_q, dst_ip_q, ports_q, dmac_lo_q, frame_cnt_q;
    logic [15:0] dmac_hi_q;

    // Per-frame snapshot
    logic [15:0] l_size_q, l_id_q, l_cksum_q;
    logic [31:0] l_src_ip_q, l_dst_ip_q, l_ports_q;
    logic [47:0] l_dmac_q;

    state_e      state_q, state_d;
    logic [3:0]  widx_q, widx_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic        start, cnt_inc;

    logic [31:0] rd_data, wr_val;
    logic [15:0] cur_ip_len, cur_cksum, l_ip_len, l_udp_len;
    logic [31:0] hdr_word;

    always_comb begin
        rd_data = 32'h0;
        case (csr_address)
            CSR_CTRL:    rd_data = {size_q, 15'h0, enable_q};
            CSR_SRC_IP:  rd_data = src_ip_q;
            CSR_DST_IP:  rd_data = dst_ip_q;
            CSR_PORTS:   rd_data = ports_q;
            CSR_DMAC_LO: rd_data = dmac_lo_q;
            CSR_DMAC_HI: rd_data = {16'h0, dmac_hi_q};
            CSR_STATUS:  rd_data = {31'h0, state_q != ST_IDLE};
            CSR_COUNT:   rd_data = frame_cnt_q;
            default:     rd_data = 32'h0;
        endcase
    end

    assign csr_readdata = rd_data;
    assign wr_val       = be_merge(rd_data, csr_writedata, csr_byteenable);

    assign cur_ip_len = 16'd28 + {size_q[13:0], 2'b00};
    assign l_ip_len   = 16'd28 + {l_size_q[13:0], 2'b00};
    assign l_udp_len  = 16'd8 + {l_size_q[13:0], 2'b00};

    // Checksum is computed from live config and captured together with it at frame start.
    udp_ip_checksum u_cksum (
        .hw0_i   (16'h4500),
        .hw1_i   (cur_ip_len),
        .hw2_i   (frame_cnt_q[15:0]),
        .hw3_i   (16'h4000),
        .hw4_i   ({IP_TTL, IP_PROTO_UDP}),
        .hw5_i   (16'h0000),
        .hw6_i   (src_ip_q[31:16]),
        .hw7_i   (src_ip_q[15:0]),
        .hw8_i   (dst_ip_q[31:16]),
        .hw9_i   (dst_ip_q[15:0]),
        .cksum_o (cur_cksum)
    );

    always_comb begin
        hdr_word = 32'h0;
        case (widx_q)
            4'd0:    hdr_word = {16'h0000, l_dmac_q[47:32]};
            4'd1:    hdr_word = l_dmac_q[31:0];
            4'd2:    hdr_word = SRC_MAC[47:16];
            4'd3:    hdr_word = {SRC_MAC[15:0], ETHERTYPE_IPV4};
            4'd4:    hdr_word = {8'h45, 8'h00, l_ip_len};
            4'd5:    hdr_word = {l_id_q, 16'h4000};
            4'd6:    hdr_word = {IP_TTL, IP_PROTO_UDP, l_cksum_q};
            4'd7:    hdr_word = l_src_ip_q;
            4'd8:    hdr_word = l_dst_ip_q;
            4'd9:    hdr_word = l_ports_q;
            4'd10:   hdr_word = {l_udp_len, 16'h0000};
            default: hdr_word = 32'h0;
        endcase
    end

    always_comb begin
        state_d                = state_q;
        widx_d                 = widx_q;
        pcnt_d                 = pcnt_q;
        start                  = 1'b0;
        cnt_inc                = 1'b0;
        data_out_data          = 32'h0;
        data_out_valid         = 1'b0;
        data_out_startofpacket = 1'b0;
        data_out_endofpacket   = 1'b0;
        data_in_ready          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_q && size_q != 16'h0 && data_in_valid) begin
                    start   = 1'b1;
                    state_d = ST_HEADER;
                    widx_d  = 4'd0;
                end
            end
            ST_HEADER: begin
                data_out_data          = hdr_word;
                data_out_valid         = 1'b1;
                data_out_startofpacket = (widx_q == 4'd0);
                if (data_out_ready) begin
                    if (widx_q == HDR_WORDS - 4'd1) begin
                        state_d = ST_PAYLOAD;
                        pcnt_d  = 16'h0;
                    end else begin
                        widx_d = widx_q + 4'd1;
                    end
                end
            end
            ST_PAYLOAD: begin
                data_out_data        = data_in_data;
                data_out_valid       = data_in_valid;
                data_in_ready        = data_out_ready;
                data_out_endofpacket = (pcnt_q == l_size_q - 16'd1);
                if (data_in_valid && data_out_ready) begin
                    if (pcnt_q == l_size_q - 16'd1) begin
                        state_d = ST_IDLE;
                        cnt_inc = 1'b1;
                    end else begin
                        pcnt_d = pcnt_q + 16'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign data_out_empty = 2'b00;

    always_ff @(posedge clk_clk or negedge rst_reset_n) begin
        if (!rst_reset_n) begin
            state_q <= ST_IDLE;
            widx_q  <= 4'd0;
            pcnt_q  <= 16'h0;
        end else begin
            state_q <= state_d;
            widx_q  <= widx_d;
            pcnt_q  <= pcnt_d;
        end
    end

    always_ff @(posedge clk_clk or negedge rst_reset_n) begin
        if (!rst_reset_n) begin
            size_q      <= 16'h0;
            enable_q    <= 1'b0;
            src_ip_q    <= 32'h0;
            dst_ip_q    <= 32'h0;
            ports_q     <= 32'h0;
            dmac_lo_q   <= 32'h0;
            dmac_hi_q   <= 16'h0;
            frame_cnt_q <= 32'h0;
            l_size_q    <= 16'h0;
            l_id_q      <= 16'h0;
            l_cksum_q   <= 16'h0;
            l_src_ip_q  <= 32'h0;
            l_dst_ip_q  <= 32'h0;
            l_ports_q   <= 32'h0;
            l_dmac_q    <= 48'h0;
        end else begin
            if (csr_write) begin
                case (csr_address)
                    CSR_CTRL: begin
                        size_q   <= wr_val[31:16];
                        enable_q <= wr_val[0];
                    end
                    CSR_SRC_IP:  src_ip_q  <= wr_val;
                    CSR_DST_IP:  dst_ip_q  <= wr_val;
                    CSR_PORTS:   ports_q   <= wr_val;
                    CSR_DMAC_LO: dmac_lo_q <= wr_val;
                    CSR_DMAC_HI: dmac_hi_q <= wr_val[15:0];
                    default: ;
                endcase
            end
            if (cnt_inc)
                frame_cnt_q <= frame_cnt_q + 32'd1;
            if (start) begin
                l_size_q   <= size_q;
                l_id_q     <= frame_cnt_q[15:0];
                l_cksum_q  <= cur_cksum;
                l_src_ip_q <= src_ip_q;
                l_dst_ip_q <= dst_ip_q;
                l_ports_q  <= ports_q;
                l_dmac_q   <= {dmac_hi_q, dmac_lo_q};
            end
        end
    end

endmodule

// File: tb/tb_udp_frame_generator.sv
// Scoreboard bench for udp_frame_generator: CSR access, frame content, stalls, gaps, disable, reset.
module tb_udp_frame_generator;

    localparam logic [15:0] CFG_SIZE  = 16'd16;
    localparam logic [31:0] CFG_SIP   = 32'h0A000711;
    localparam logic [31:0] CFG_DIP   = 32'h0A000701;
    localparam logic [31:0] CFG_PORTS = 32'h01000100;
    localparam logic [31:0] CFG_DMLO  = 32'hC705AA63;
    localparam logic [15:0] CFG_DMHI  = 16'h18D6;
    localparam logic [47:0] M_SRC_MAC = 48'h0007ED000001;
    localparam logic [7:0]  M_TTL     = 8'h40;
    localparam int          GAP_AT    = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  csr_address = '0;
    logic        csr_write = 1'b0;
    logic [31:0] csr_writedata = '0;
    logic [3:0]  csr_byteenable = '0;
    logic        csr_read = 1'b0;
    logic [31:0] csr_readdata;
    logic [31:0] data_in_data;
    logic        data_in_ready;
    logic        data_in_valid;
    logic [1:0]  data_in_empty = 2'b00;
    logic        data_in_endofpacket = 1'b0;
    logic        data_in_startofpacket = 1'b0;
    logic [31:0] data_out_data;
    logic [1:0]  data_out_empty;
    logic        data_out_endofpacket;
    logic        data_out_startofpacket;
    logic        data_out_ready = 1'b0;
    logic        data_out_valid;

    int checks = 0;
    int failures = 0;
    logic [33:0] exp_q[$];
    int eop_cnt = 0;
    int sop_cnt = 0;
    int frame_words = 0;
    bit src_on = 1'b0;
    int src_idx = 0;

    always #5 clk = ~clk;

    udp_frame_generator dut (
        .clk_clk               (clk),
        .rst_reset_n           (rst_n),
        .csr_address           (csr_address),
        .csr_write             (csr_write),
        .csr_writedata         (csr_writedata),
        .csr_byteenable        (csr_byteenable),
        .csr_read              (csr_read),
        .csr_readdata          (csr_readdata),
        .data_in_data          (data_in_data),
        .data_in_ready         (data_in_ready),
        .data_in_valid         (data_in_valid),
        .data_in_empty         (data_in_empty),
        .data_in_endofpacket   (data_in_endofpacket),
        .data_in_startofpacket (data_in_startofpacket),
        .data_out_data         (data_out_data),
        .data_out_empty        (data_out_empty),
        .data_out_endofpacket  (data_out_endofpacket),
        .data_out_startofpacket(data_out_startofpacket),
        .data_out_ready        (data_out_ready),
        .data_out_valid        (data_out_valid)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] pay_word(input int n);
        return 32'hC0DE0000 + n;
    endfunction

    function automatic logic [15:0] model_cksum(input logic [15:0] id);
        logic [15:0] h[10];
        int unsigned s;
        logic [15:0] ip_len;
        ip_len = 16'(20 + 8 + 4 * CFG_SIZE);
        h = '{16'h4500, ip_len, id, 16'h4000, {M_TTL, 8'h11}, 16'h0000,
              CFG_SIP[31:16], CFG_SIP[15:0], CFG_DIP[31:16], CFG_DIP[15:0]};
        s = 0;
        for (int i = 0; i < 10; i++) s += h[i];
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        return ~s[15:0];
    endfunction

    function automatic logic [31:0] model_hdr(input int i, input logic [15:0] id);
        logic [15:0] ip_len, udp_len;
        ip_len  = 16'(20 + 8 + 4 * CFG_SIZE);
        udp_len = 16'(8 + 4 * CFG_SIZE);
        case (i)
            0:  return {16'h0000, CFG_DMHI};
            1:  return CFG_DMLO;
            2:  return M_SRC_MAC[47:16];
            3:  return {M_SRC_MAC[15:0], 16'h0800};
            4:  return {8'h45, 8'h00, ip_len};
            5:  return {id, 16'h4000};
            6:  return {M_TTL, 8'h11, model_cksum(id)};
            7:  return CFG_SIP;
            8:  return CFG_DIP;
            9:  return CFG_PORTS;
            10: return {udp_len, 16'h0000};
            default: return 32'h0;
        endcase
    endfunction

    task automatic push_frame(input logic [15:0] id, input int base);
        for (int i = 0; i < 11; i++)
            exp_q.push_back({i == 0, 1'b0, model_hdr(i, id)});
        for (int k = 0; k < CFG_SIZE; k++)
            exp_q.push_back({1'b0, k == CFG_SIZE - 1, pay_word(base + k)});
    endtask

    // ---------------- driver tasks ----------------
    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        @(posedge clk); #1;
        csr_address = a; csr_writedata = d; csr_byteenable = be; csr_write = 1'b1;
        @(posedge clk); #1;
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        csr_address = a; csr_read = 1'b1;
        @(negedge clk);
        d = csr_readdata;
        csr_read = 1'b0;
    endtask

    task automatic csr_expect(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        csr_rd(a, d);
        check(tag, d, exp);
    endtask

    task automatic wait_eops(input int n, input string tag);
        int budget = 400;
        while (eop_cnt < n && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (budget == 0) check(tag, 64'(eop_cnt), 64'(n));
    endtask

    task automatic wait_out_valid(input string tag);
        int budget = 50;
        @(negedge clk);
        while (!data_out_valid && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check(tag, 64'(data_out_valid), 64'd1);
    endtask

    // ---------------- payload source ----------------
    initial begin
        bit take;
        bit gap_done = 1'b0;
        int gap_left = 0;
        data_in_valid = 1'b0;
        data_in_data  = pay_word(0);
        forever begin
            @(negedge clk);
            take = data_in_valid && data_in_ready;
            @(posedge clk); #1;
            if (take) src_idx++;
            if (take && src_idx == GAP_AT && !gap_done) begin
                gap_left = 3;
                gap_done = 1'b1;
            end
            data_in_valid = src_on && (gap_left == 0);
            if (gap_left > 0) gap_left--;
            data_in_data = pay_word(src_idx);
        end
    end

    // ---------------- output monitor / scoreboard ----------------
    initial begin
        logic [33:0] exp_w;
        forever begin
            @(negedge clk);
            if (src_on && !data_in_valid && rst_n)
                check("gap_out_valid", 64'(data_out_valid), 64'd0);
            if (data_out_valid && data_out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {data_out_startofpacket, data_out_endofpacket, data_out_data}, 64'h0);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("frame_word", {data_out_startofpacket, data_out_endofpacket, data_out_data}, exp_w);
                end
                if (data_out_startofpacket) begin
                    sop_cnt++;
                    frame_words = 0;
                end
                frame_words++;
                if (data_out_endofpacket) eop_cnt++;
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] d;

        #1;
        check("rst_out_valid", 64'(data_out_valid), 64'd0);
        check("rst_out_sop_eop", {data_out_startofpacket, data_out_endofpacket}, 64'd0);
        check("rst_out_data", data_out_data, 64'd0);
        check("rst_in_ready", 64'(data_in_ready), 64'd0);
        check("rst_out_empty", 64'(data_out_empty), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int a = 0; a < 8; a++) csr_expect("rst_reg", 3'(a), 32'h0);

        // Config and byte-enable masking
        csr_wr(3'd1, CFG_SIP, 4'hF);
        csr_wr(3'd1, 32'hFFFFFFFF, 4'h0);
        csr_expect("be_none", 3'd1, CFG_SIP);
        csr_wr(3'd1, 32'h000000EE, 4'h1);
        csr_expect("be_lane0", 3'd1, 32'h0A0007EE);
        csr_wr(3'd1, CFG_SIP, 4'hF);
        csr_wr(3'd2, CFG_DIP, 4'hF);
        csr_wr(3'd3, CFG_PORTS, 4'hF);
        csr_wr(3'd4, CFG_DMLO, 4'hF);
        csr_wr(3'd5, {16'h0, CFG_DMHI}, 4'hF);
        csr_wr(3'd0, {CFG_SIZE, 16'h0001}, 4'hF);
        csr_expect("rb_reg0", 3'd0, 32'h00100001);
        csr_expect("rb_reg1", 3'd1, CFG_SIP);
        csr_expect("rb_reg2", 3'd2, CFG_DIP);
        csr_expect("rb_reg3", 3'd3, CFG_PORTS);
        csr_expect("rb_reg4", 3'd4, CFG_DMLO);
        csr_expect("rb_reg5", 3'd5, 32'h000018D6);
        csr_expect("rb_reg7", 3'd7, 32'h0);
        csr_expect("idle_busy", 3'd6, 32'h0);

        // Frame 0 with initial backpressure, frame 1 follows back to back
        push_frame(16'd0, 0);
        push_frame(16'd1, CFG_SIZE);
        src_on = 1'b1;
        wait_out_valid("w0_timeout");
        for (int c = 0; c < 2; c++) begin
            check("stall_w0_data", data_out_data, {16'h0, CFG_DMHI});
            check("stall_w0_sop", 64'(data_out_startofpacket), 64'd1);
            check("stall_in_ready", 64'(data_in_ready), 64'd0);
            if (c == 0) @(negedge clk);
        end
        @(posedge clk); #1;
        data_out_ready = 1'b1;

        wait_eops(1, "frame0_timeout");
        csr_expect("count_after_f0", 3'd7, 32'd1);
        csr_expect("busy_f1", 3'd6, 32'd1);

        // Disable in the middle of frame 1's payload
        begin
            int budget = 200;
            while (!(sop_cnt == 2 && frame_words >= 15) && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            if (budget == 0) check("f1_payload_timeout", 64'(frame_words), 64'd15);
        end
        csr_wr(3'd0, {CFG_SIZE, 16'h0000}, 4'hF);
        wait_eops(2, "frame1_timeout");
        repeat (30) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("no_new_sop", 64'(sop_cnt), 64'd2);
        csr_expect("count_after_f1", 3'd7, 32'd2);
        csr_expect("busy_off", 3'd6, 32'd0);
        csr_expect("reg0_disabled", 3'd0, 32'h00100000);

        // Simultaneous write and read returns the old value
        @(posedge clk); #1;
        csr_address = 3'd3; csr_writedata = 32'h12345678; csr_byteenable = 4'hF;
        csr_write = 1'b1; csr_read = 1'b1;
        @(negedge clk);
        check("wr_rd_old", csr_readdata, CFG_PORTS);
        @(posedge clk); #1;
        csr_write = 1'b0; csr_read = 1'b0;
        csr_expect("wr_rd_new", 3'd3, 32'h12345678);

        // Reset while a frame sits in its header
        data_out_ready = 1'b0;
        csr_wr(3'd0, {CFG_SIZE, 16'h0001}, 4'hF);
        wait_out_valid("f2_w0_timeout");
        check("f2_w0_sop", 64'(data_out_startofpacket), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(data_out_valid), 64'd0);
        check("arst_out_sop", 64'(data_out_startofpacket), 64'd0);
        check("arst_out_data", data_out_data, 64'd0);
        check("arst_in_ready", 64'(data_in_ready), 64'd0);
        src_on = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        csr_expect("arst_reg0", 3'd0, 32'h0);
        csr_expect("arst_reg3", 3'd3, 32'h0);
        csr_expect("arst_reg6", 3'd6, 32'h0);
        csr_expect("arst_reg7", 3'd7, 32'h0);
        @(negedge clk);
        check("post_rst_valid", 64'(data_out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/udp_frame_generator.md
Name: udp_frame_generator

Overview:
- Wraps a continuous 32-bit Avalon-ST data stream into fixed-size Ethernet/IPv4/UDP frames.
- Each frame is 11 header words followed by SIZE payload words taken from the input stream.
- Output feeds a TSE-style MAC in 16-bit-shift TX mode.
- Configured through a 3-bit Avalon-MM CSR slave. Sits between the DAQ data FIFO and the Ethernet MAC.

Parameters:
SRC_MAC, 48'h0007ED000001, source MAC address inserted in every frame
IP_TTL, 8'h40, IPv4 time-to-live

Ports:
clk_clk  in  1  clock
rst_reset_n  in  1  asynchronous active-low reset
csr_address  in  3  register index
csr_write  in  1  write strobe
csr_writedata  in  32  write data
csr_byteenable  in  4  byte lanes for write
csr_read  in  1  read strobe
csr_readdata  out  32  read data, combinational (read latency 0)
data_in_data  in  32  payload word, first byte on [31:24]
data_in_ready  out  1  sink ready (readyLatency 0)
data_in_valid  in  1  sink valid
data_in_empty  in  2  ignored
data_in_endofpacket  in  1  ignored (input treated as a stream)
data_in_startofpacket  in  1  ignored
data_out_data  out  32  frame word
data_out_empty  out  2  always 0
data_out_endofpacket  out  1  last payload word of frame
data_out_startofpacket  out  1  header word 0
data_out_ready  in  1  downstream ready
data_out_valid  out  1  source valid

Behaviour:
- CSR map; writes are byte-enable masked and all registers are readable:
  - 0: [31:16] SIZE (payload words), [0] ENABLE
  - 1: SRC_IP
  - 2: DST_IP
  - 3: [31:16] SRC_PORT, [15:0] DST_PORT
  - 4: DST_MAC[31:0]
  - 5: [15:0] DST_MAC[47:32]
  - 6 (read-only): [0] busy
  - 7 (read-only): 32-bit sent-frame counter
- Reset values:
  - All registers and the counter 0, FSM in IDLE.
  - data_out_valid, data_out_startofpacket, data_out_endofpacket, data_in_ready = 0; data_out_data = 0.
- FSM IDLE -> HEADER -> PAYLOAD -> IDLE:
  - IDLE: if ENABLE=1 and SIZE!=0 and data_in_valid=1, latch all config (SIZE, IPs, ports, DST_MAC, ID = counter[15:0]) and the IP checksum, then go to HEADER. The frame only starts once payload data is available.
  - HEADER: data_out_valid=1 and word index 0..10. Word advances only on data_out_ready=1. data_in_ready=0.
  - PAYLOAD: data_out_data=data_in_data, data_out_valid=data_in_valid, data_in_ready=data_out_ready. A word is transferred when valid&ready. After SIZE transfers, return to IDLE and increment the counter. endofpacket is asserted with word SIZE.
- Header words, big-endian:
  - W0 = {16'h0000 pad, DST_MAC[47:32]}
  - W1 = DST_MAC[31:0]
  - W2 = SRC_MAC[47:16]
  - W3 = {SRC_MAC[15:0], 16'h0800}
  - W4 = {8'h45, 8'h00, 20+8+4*SIZE}
  - W5 = {ID, 16'h4000}
  - W6 = {IP_TTL, 8'h11, CKSUM}
  - W7 = SRC_IP
  - W8 = DST_IP
  - W9 = {SRC_PORT, DST_PORT}
  - W10 = {8+4*SIZE, 16'h0000} (UDP checksum disabled)
- Arithmetic:
  - Length fields are computed modulo 2^16. Software keeps SIZE ≤ 368.
  - CKSUM is the ones' complement of the end-around-carry ones'-complement sum of the ten IP header halfwords, with the checksum halfword taken as 0.
- Config writes during a frame do not affect it; the latched copy is used. Clearing ENABLE mid-frame finishes the current frame, then the block stays in IDLE.
- Stalls (data_out_ready=0) hold data_out_data/valid stable. An input valid gap in PAYLOAD holds state.
- Async reset mid-frame aborts immediately to the reset state. No partial-frame recovery.
- Simultaneous CSR write and CSR read: the read returns the old value.

Decomposition:
- Package udp_gen_pkg holds: CSR address constants, ETHERTYPE_IPV4 = 16'h0800, IP_PROTO_UDP = 8'h11, HDR_WORDS = 11, and the FSM state enum.
- One sub-module, udp_ip_checksum: purely combinational, ten 16-bit inputs to a 16-bit checksum.

Test Plan:
- Config write/readback: write reg0=0x00100001, reg1=0x0A000711, reg2=0x0A000701, reg3=0x01000100, reg4=0xC705AA63, reg5=0x000018D6 -> each reads back the same value; reg7=0.
- Frame content: with the config above, hold data_in_valid=1 and data_out_ready=1 -> expect, in order:
  - W0=0x000018D6 with sop
  - W1=0xC705AA63
  - W4=0x4500005C
  - W5=0x00004000
  - W6=0x40111880
  - W9=0x01000100
  - W10=0x00480000
  - then 16 payload words, eop on the 16th.
  - reg7 then reads 1; the next frame's W5 = 0x00014000.
- Backpressure: data_out_ready=0 for 2 cycles at the start of a frame -> W0 held stable, data_in_ready=0, nothing lost.
- Input gaps: deassert data_in_valid for 3 cycles mid-payload -> data_out_valid=0 during the gap, still exactly 16 payload words.
- Disable: ENABLE=0 written mid-payload -> the frame completes with eop, then no new sop.
- Reset mid-frame: rst_reset_n low during HEADER -> all outputs 0 immediately; registers cleared.
